// File: rtl/return_stack.sv
// return_stack: ring-buffer return address stack with sticky over/underflow.
// Ports: i_clk, i_rst_n, i_push/i_pop/i_flush/i_err_clr, i_din -> o_dout,
//        o_count, o_empty, o_full, o_overflow, o_underflow.
module return_stack #(
  parameter int DataWidth = 16,
  parameter int Depth     = 8,
  parameter int WrapMode  = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_flush,
  input  logic                         i_err_clr,
  input  logic [DataWidth-1:0]         i_din,
  output logic [DataWidth-1:0]         o_dout,
  output logic [$clog2(Depth+1)-1:0]   o_count,
  output logic                         o_empty,
  output logic                         o_full,
  output logic                         o_overflow,
  output logic                         o_underflow
);

  localparam int CW = $clog2(Depth + 1);
  localparam int PW = $clog2(Depth);
  localparam logic [CW-1:0] CntMax = CW'(Depth);
  localparam logic [PW-1:0] PtrMax = PW'(Depth - 1);

  logic [DataWidth-1:0] r_mem [Depth];
  logic [PW-1:0]        r_ptr;
  logic [CW-1:0]        r_cnt;
  logic                 r_ov;
  logic                 r_un;

  logic [PW-1:0]        w_ptr_up;
  logic [PW-1:0]        w_ptr_dn;
  logic [PW-1:0]        w_ptr_n;
  logic [CW-1:0]        w_cnt_n;
  logic                 w_ov_n;
  logic                 w_un_n;
  logic                 w_we;
  logic [PW-1:0]        w_waddr;
  logic                 w_empty;
  logic                 w_full;

  // Ring wrap handled explicitly so non-power-of-two depths work.
  assign w_ptr_up = (r_ptr == PtrMax) ? '0 : r_ptr + PW'(1);
  assign w_ptr_dn = (r_ptr == '0) ? PtrMax : r_ptr - PW'(1);

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CntMax);

  always_comb begin
    w_ptr_n = r_ptr;
    w_cnt_n = r_cnt;
    w_ov_n  = r_ov & ~i_err_clr;
    w_un_n  = r_un & ~i_err_clr;
    w_we    = 1'b0;
    w_waddr = w_ptr_up;
    if (i_flush) begin
      w_ptr_n = '0;
      w_cnt_n = '0;
    end else begin
      unique case ({i_push, i_pop})
        2'b10: begin
          if (!w_full) begin
            w_we    = 1'b1;
            w_ptr_n = w_ptr_up;
            w_cnt_n = r_cnt + CW'(1);
          end else begin
            w_ov_n = 1'b1;
            // Circular mode: slot above top is the oldest entry.
            if (WrapMode != 0) begin
              w_we    = 1'b1;
              w_ptr_n = w_ptr_up;
            end
          end
        end
        2'b01: begin
          if (!w_empty) begin
            w_ptr_n = w_ptr_dn;
            w_cnt_n = r_cnt - CW'(1);
          end else begin
            w_un_n = 1'b1;
          end
        end
        2'b11: begin
          if (!w_empty) begin
            w_we    = 1'b1;
            w_waddr = r_ptr;
          end else begin
            w_we    = 1'b1;
            w_ptr_n = w_ptr_up;
            w_cnt_n = CW'(1);
            w_un_n  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
      r_cnt <= '0;
      r_ov  <= 1'b0;
      r_un  <= 1'b0;
    end else begin
      r_ptr <= w_ptr_n;
      r_cnt <= w_cnt_n;
      r_ov  <= w_ov_n;
      r_un  <= w_un_n;
    end
  end

  // Storage is not reset; Count gates visibility on DOut.
  always_ff @(posedge i_clk) begin
    if (w_we && i_rst_n) begin
      r_mem[w_waddr] <= i_din;
    end
  end

  assign o_dout      = w_empty ? '0 : r_mem[r_ptr];
  assign o_count     = r_cnt;
  assign o_empty     = w_empty;
  assign o_full      = w_full;
  assign o_overflow  = r_ov;
  assign o_underflow = r_un;

endmodule

// File: tb/tb_return_stack.sv
// tb_return_stack: directed checks of return_stack in reject and wrap modes.
// Both instances share stimulus; each phase checks the instance of interest.
module tb_return_stack;

  logic        clk;
  logic        rst_n;
  logic        push;
  logic        pop;
  logic        flush;
  logic        clr;
  logic [15:0] din;

  logic [15:0] d0, d1;
  logic [3:0]  c0, c1;
  logic        e0, e1, f0, f1, ov0, ov1, un0, un1;

  int checks = 0;
  int errors = 0;

  return_stack #(.DataWidth(16), .Depth(8), .WrapMode(0)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_push(push), .i_pop(pop),
    .i_flush(flush), .i_err_clr(clr), .i_din(din),
    .o_dout(d0), .o_count(c0), .o_empty(e0), .o_full(f0),
    .o_overflow(ov0), .o_underflow(un0)
  );

  return_stack #(.DataWidth(16), .Depth(8), .WrapMode(1)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_push(push), .i_pop(pop),
    .i_flush(flush), .i_err_clr(clr), .i_din(din),
    .o_dout(d1), .o_count(c1), .o_empty(e1), .o_full(f1),
    .o_overflow(ov1), .o_underflow(un1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic pu, input logic po, input logic fl,
                      input logic cl, input logic [15:0] d);
    push  = pu;
    pop   = po;
    flush = fl;
    clr   = cl;
    din   = d;
    @(posedge clk);
    #1;
    push  = 1'b0;
    pop   = 1'b0;
    flush = 1'b0;
    clr   = 1'b0;
    din   = '0;
  endtask

  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    flush = 1'b0;
    clr   = 1'b0;
    din   = '0;
    #3;
    chk("rst_count", 32'(c0), 32'd0);
    chk("rst_empty", 32'(e0), 32'd1);
    chk("rst_full", 32'(f0), 32'd0);
    chk("rst_dout", 32'(d0), 32'd0);
    chk("rst_ov", 32'(ov0), 32'd0);
    chk("rst_un", 32'(un0), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fill, first push visible one cycle later
    step(1, 0, 0, 0, 16'h0010);
    chk("push1_count", 32'(c0), 32'd1);
    chk("push1_dout", 32'(d0), 32'h10);
    for (int i = 1; i < 8; i++) step(1, 0, 0, 0, 16'(16'h0010 + i));
    chk("fill_full", 32'(f0), 32'd1);
    chk("fill_count", 32'(c0), 32'd8);
    chk("fill_dout", 32'(d0), 32'h17);
    chk("fill_ov", 32'(ov0), 32'd0);
    step(1, 0, 0, 0, 16'h0099);
    chk("ovf_dout", 32'(d0), 32'h17);
    chk("ovf_flag", 32'(ov0), 32'd1);
    chk("ovf_count", 32'(c0), 32'd8);

    // Drain
    for (int i = 0; i < 7; i++) begin
      step(0, 1, 0, 0, 16'h0);
      chk("pop_dout", 32'(d0), 32'(16'h0016 - i));
    end
    step(0, 1, 0, 0, 16'h0);
    chk("pop8_dout", 32'(d0), 32'h0);
    chk("pop8_empty", 32'(e0), 32'd1);
    chk("pop8_un", 32'(un0), 32'd0);
    step(0, 1, 0, 0, 16'h0);
    chk("unf_flag", 32'(un0), 32'd1);
    chk("unf_count", 32'(c0), 32'd0);

    // Circular mode
    pulse_reset();
    chk("rst2_ov", 32'(ov1), 32'd0);
    chk("rst2_count", 32'(c1), 32'd0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 16'(16'h0010 + i));
    step(1, 0, 0, 0, 16'h00AA);
    chk("wrap_count", 32'(c1), 32'd8);
    chk("wrap_dout", 32'(d1), 32'hAA);
    chk("wrap_ov", 32'(ov1), 32'd1);
    chk("wrap_full", 32'(f1), 32'd1);
    chk("wrap_r0_dout", 32'(d0), 32'h17);
    step(0, 1, 0, 0, 16'h0);
    chk("wrap_pop0", 32'(d1), 32'h17);
    for (int i = 1; i < 7; i++) begin
      step(0, 1, 0, 0, 16'h0);
      chk("wrap_pop", 32'(d1), 32'(16'h0017 - i));
    end
    chk("wrap_last_count", 32'(c1), 32'd1);
    step(0, 1, 0, 0, 16'h0);
    chk("wrap_drain_empty", 32'(e1), 32'd1);
    chk("wrap_drain_dout", 32'(d1), 32'h0);

    // Push+Pop replace
    step(0, 0, 0, 1, 16'h0);
    chk("clr_ov", 32'(ov0), 32'd0);
    chk("clr_un", 32'(un0), 32'd0);
    step(1, 0, 0, 0, 16'h0040);
    step(1, 0, 0, 0, 16'h0041);
    step(1, 0, 0, 0, 16'h0042);
    chk("pp_pre_dout", 32'(d0), 32'h42);
    step(1, 1, 0, 0, 16'h0055);
    chk("pp_count", 32'(c0), 32'd3);
    chk("pp_dout", 32'(d0), 32'h55);
    chk("pp_ov", 32'(ov0), 32'd0);
    chk("pp_un", 32'(un0), 32'd0);
    step(0, 1, 0, 0, 16'h0);
    chk("pp_below", 32'(d0), 32'h41);
    step(0, 0, 1, 0, 16'h0);
    chk("flush_count", 32'(c0), 32'd0);
    chk("flush_dout", 32'(d0), 32'h0);
    step(1, 1, 0, 0, 16'h0001);
    chk("ppe_count", 32'(c0), 32'd1);
    chk("ppe_dout", 32'(d0), 32'h1);
    chk("ppe_un", 32'(un0), 32'd1);

    // Push+Pop while full sets nothing
    step(0, 0, 1, 1, 16'h0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 16'(16'h0020 + i));
    step(1, 1, 0, 0, 16'h0077);
    chk("ppf_count", 32'(c0), 32'd8);
    chk("ppf_dout", 32'(d0), 32'h77);
    chk("ppf_ov", 32'(ov0), 32'd0);
    chk("ppf_un", 32'(un0), 32'd0);

    // Flush + Push + Err_Clr at Count=5 with Overflow set
    step(1, 0, 0, 0, 16'h0088);
    chk("ov_again", 32'(ov0), 32'd1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 16'h0);
    chk("c5_count", 32'(c0), 32'd5);
    chk("c5_dout", 32'(d0), 32'h24);
    step(1, 0, 1, 1, 16'h0066);
    chk("fpc_count", 32'(c0), 32'd0);
    chk("fpc_dout", 32'(d0), 32'h0);
    chk("fpc_ov", 32'(ov0), 32'd0);
    step(0, 1, 0, 1, 16'h0);
    chk("clr_unf_flag", 32'(un0), 32'd1);
    chk("clr_unf_count", 32'(c0), 32'd0);

    // Asynchronous reset mid-cycle
    step(1, 0, 0, 0, 16'h0011);
    step(1, 0, 0, 0, 16'h0012);
    chk("pre_arst_count", 32'(c0), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(c0), 32'd0);
    chk("arst_dout", 32'(d0), 32'h0);
    chk("arst_empty", 32'(e0), 32'd1);
    chk("arst_un", 32'(un0), 32'd0);
    #1;
    rst_n = 1'b1;
    step(1, 0, 0, 0, 16'h0033);
    chk("post_count", 32'(c0), 32'd1);
    chk("post_dout", 32'(d0), 32'h33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/return_stack.md
RETURN_STACK -- requirements
Module: return_stack

Interface
REQ-001 Parameter DataWidth, default 16: entry width in bits.
REQ-002 Parameter Depth, default 8: number of entries; SHALL be >= 2.
REQ-003 Parameter WrapMode, default 0: 0 = reject push when full; 1 = circular, push when full overwrites the oldest entry.
REQ-004 Clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Reset  input  1  asynchronous, active-low; asserted at 0.
REQ-006 Push  input  1  push DIn this cycle.
REQ-007 Pop  input  1  pop top entry this cycle.
REQ-008 Flush  input  1  discard all entries.
REQ-009 Err_Clr  input  1  clear sticky error flags.
REQ-010 DIn  input  DataWidth  value to push (return address).
REQ-011 DOut  output  DataWidth  current top of stack, combinational from state.
REQ-012 Count  output  clog2(Depth+1)  number of valid entries.
REQ-013 Empty  output  1  Count == 0.
REQ-014 Full  output  1  Count == Depth.
REQ-015 Overflow  output  1  sticky: a push was made while Full.
REQ-016 Underflow  output  1  sticky: a pop was made while Empty.

Function
REQ-017 Storage SHALL be a ring of Depth entries with a top pointer of clog2(Depth) bits, wrapping modulo Depth.
REQ-018 DOut SHALL equal the entry at the top pointer when Count > 0 and all zeros when Empty.
REQ-019 A push SHALL be visible on DOut and Count in the cycle after the edge that accepts it (latency 1).
REQ-020 Push only, not Full: write DIn above top; Count +1.
REQ-021 Push only, Full, WrapMode 0: storage, pointer and Count unchanged; Overflow set.
REQ-022 Push only, Full, WrapMode 1: write DIn above top, overwriting the oldest entry; Count stays Depth; Overflow set.
REQ-023 Pop only, not Empty: Count -1; top pointer moves down one; entry contents are not cleared.
REQ-024 Pop only, Empty: no state change except Underflow set.
REQ-025 Push and Pop, not Empty: replace top entry with DIn; Count and pointer unchanged; no flag set, including when Full.
REQ-026 Push and Pop, Empty: treated as a push of DIn (Count becomes 1); Underflow set.
REQ-027 Flush SHALL take priority over Push and Pop: Count goes to 0 and the pointer returns to its reset position; storage contents and flags are unchanged.
REQ-028 Err_Clr SHALL clear Overflow and Underflow; when it coincides with a new error event, the flag for that event SHALL be set.
REQ-029 Count SHALL never exceed Depth and never wrap below 0.

Reset
REQ-030 While Reset is 0, asynchronously: Count = 0, pointer = 0, Overflow = 0, Underflow = 0, Empty = 1, Full = 0, DOut = 0.
REQ-031 Storage entries are not required to be reset; they SHALL never be visible on DOut until written.
REQ-032 Reset asserted during any operation SHALL abort it; the first edge after release SHALL act on inputs normally.

Verification
REQ-033 Depth=8, WrapMode=0: push 0x0010..0x0017 -> Full=1, Count=8, DOut=0x0017; push 0x0099 -> DOut=0x0017, Overflow=1.
REQ-034 From REQ-033 state, 8 pops -> DOut sequence 0x0016..0x0010 then 0, Empty=1; 9th pop -> Underflow=1, Count=0.
REQ-035 WrapMode=1, 8 pushes then push 0x00AA -> Count=8, DOut=0x00AA, Overflow=1; 8 pops return 0x00AA, 0x0017..0x0011.
REQ-036 Count=3, top 0x0042, Push+Pop with DIn=0x0055 -> Count=3, DOut=0x0055, no flags; Push+Pop while Empty with DIn=0x0001 -> Count=1, DOut=0x0001, Underflow=1.
REQ-037 Count=5 with Flush, Push and Err_Clr together, Overflow=1 -> Count=0, DOut=0, Overflow=0; then Err_Clr with a pop on empty -> Underflow=1.
REQ-038 Reset driven to 0 mid-stream between clock edges -> all outputs at reset values immediately, without waiting for a Clk edge; first push after release -> Count=1.
